// File: rtl/serial_link_pkg.sv
// ============================================================================
// Package     : serial_link_pkg
// Description : Types and constants shared by both ends of the single-wire
//               serial link: frame FSM state encoding, line levels, and a
//               frame-length helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_link_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Clock cycles occupied by one frame: start + data + optional parity + stop.
    function automatic int frame_cycles(input int width,
                                        input int clks_per_bit,
                                        input bit parity_en);
        return (width + 2 + (parity_en ? 1 : 0)) * clks_per_bit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_frame_tx_bit_timer.sv
// ============================================================================
// Module      : bit_timer
// Description : Bit-period divider. Counts clk cycles and raises tick during
//               the last cycle of each CLKS_PER_BIT-cycle bit period. State
//               updates on the falling edge of clk.
// Ports       : clk   - clock (falling-edge active)
//               rst   - asynchronous active-high reset
//               clear - hold/force the counter to zero
//               tick  - high in the final cycle of a bit period
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(CLKS_PER_BIT - 1));

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/serial_frame_tx.sv
// ============================================================================
// Module      : serial_frame_tx
// Description : Parallel-in, serial-out frame transmitter. Accepts a WIDTH-bit
//               word on a valid/ready handshake and sends start bit, data
//               bits (LSB or MSB first), optional even parity, and stop bit,
//               each held CLKS_PER_BIT cycles. All state updates on the
//               falling edge of clk.
// Build macro : SERIAL_FRAME_TX_PARITY_EN - adds an even-parity bit between
//               the data bits and the stop bit.
// Ports       : clk        - clock (falling-edge active)
//               rst        - asynchronous active-high reset
//               load_valid - producer offers load_data
//               load_data  - word to transmit
//               load_ready - transmitter can accept a word this cycle
//               sdo        - serial line, idles high
//               busy       - frame in progress
//               done       - one-cycle pulse in the final stop-bit cycle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_frame_tx
    import serial_link_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int LSB_FIRST    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sdo,
    output logic             busy,
    output logic             done
);

    localparam int BCW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] shreg;
    logic [BCW-1:0]   bit_cnt;
    logic             tick;
    logic             accept;
    logic             last_data_bit;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic             parity_bit;
`endif

    // The last stop-bit cycle doubles as the handoff cycle: done pulses and
    // a new word may be accepted, so the next start bit follows with no gap.
    assign done          = (state == STOP) && tick;
    assign load_ready    = (state == IDLE) || done;
    assign accept        = load_valid && load_ready;
    assign busy          = (state != IDLE);
    assign last_data_bit = (bit_cnt == BCW'(WIDTH - 1));

    // Divider is held at zero while idle and restarted on every acceptance so
    // that the start bit always lasts a full period.
    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst   (rst),
        .clear ((state == IDLE) || accept),
        .tick  (tick)
    );

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    state_nx = START;
                end
            end
            START: begin
                if (tick) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (tick && last_data_bit) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    state_nx = PARITY;
`else
                    state_nx = STOP;
`endif
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_nx = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_nx = load_valid ? START : IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        sdo = IDLE_LEVEL;
        case (state)
            START:   sdo = START_BIT;
            DATA:    sdo = (LSB_FIRST != 0) ? shreg[0] : shreg[WIDTH-1];
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY:  sdo = parity_bit;
`endif
            STOP:    sdo = STOP_BIT;
            default: sdo = IDLE_LEVEL;
        endcase
    end

    // Data path: the word (and its parity) is captured only on acceptance, so
    // later changes on load_data cannot disturb a frame in flight.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            shreg   <= load_data;
            bit_cnt <= '0;
        end else if ((state == DATA) && tick) begin
            if (LSB_FIRST != 0) begin
                shreg <= shreg >> 1;
            end else begin
                shreg <= shreg << 1;
            end
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

`ifdef SERIAL_FRAME_TX_PARITY_EN
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            parity_bit <= 1'b0;
        end else if (accept) begin
            parity_bit <= ^load_data;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
// ============================================================================
// Module      : tb_serial_frame_tx
// Description : Scoreboard bench for serial_frame_tx. Three instances cover
//               LSB-first / MSB-first at 4 clk per bit and LSB-first at 1 clk
//               per bit. Expected per-cycle {sdo,busy,done,load_ready} words
//               are queued when a word is accepted and compared every cycle
//               on the rising edge (the DUT updates on the falling edge).
//               Honours SERIAL_FRAME_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_frame_tx;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    localparam logic [3:0] IDLE_EXP = 4'b1001;   // sdo=1 busy=0 done=0 ready=1

    logic       clk;
    logic       rst;
    logic       lv;
    logic [7:0] ld;
    int         sel;
    logic       mon_en;

    logic sdo_a, busy_a, done_a, ready_a;
    logic sdo_b, busy_b, done_b, ready_b;
    logic sdo_c, busy_c, done_c, ready_c;
    logic lv_a, lv_b, lv_c;
    logic [3:0] obs;

    logic [3:0] sb_q[$];
    int checks;
    int errors;

    assign lv_a = lv && (sel == 0);
    assign lv_b = lv && (sel == 1);
    assign lv_c = lv && (sel == 2);

    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .LSB_FIRST(1)) dut_a (
        .clk(clk), .rst(rst), .load_valid(lv_a), .load_data(ld),
        .load_ready(ready_a), .sdo(sdo_a), .busy(busy_a), .done(done_a));

    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .LSB_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .load_valid(lv_b), .load_data(ld),
        .load_ready(ready_b), .sdo(sdo_b), .busy(busy_b), .done(done_b));

    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .LSB_FIRST(1)) dut_c (
        .clk(clk), .rst(rst), .load_valid(lv_c), .load_data(ld),
        .load_ready(ready_c), .sdo(sdo_c), .busy(busy_c), .done(done_c));

    always_comb begin
        case (sel)
            1:       obs = {sdo_b, busy_b, done_b, ready_b};
            2:       obs = {sdo_c, busy_c, done_c, ready_c};
            default: obs = {sdo_a, busy_a, done_a, ready_a};
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t dut=%0d observed %h expected %h", tag, $time, sel, got, exp);
        end
    endtask

    // Build the expected frame from the word and link settings.
    task automatic push_frame(input logic [7:0] d, input int cpb, input bit lsb);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(lsb ? d[i] : d[7-i]);
        if (PAR != 0) bits.push_back(^d);
        bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < cpb; c++) begin
                logic last;
                last = (b == bits.size() - 1) && (c == cpb - 1);
                sb_q.push_back({bits[b], 1'b1, last, last});
            end
        end
    endtask

    // Every rising edge: compare against the next queued expectation, or
    // against the idle pattern when no frame is outstanding.
    always @(posedge clk) begin
        if (mon_en) begin
            logic [3:0] e;
            e = (sb_q.size() > 0) ? sb_q.pop_front() : IDLE_EXP;
            chk("cycle", {28'd0, obs}, {28'd0, e});
        end
    end

    task automatic send(input logic [7:0] d, input int cpb, input bit lsb, input bit poke);
        int flen;
        flen = (8 + 2 + PAR) * cpb;
        @(negedge clk); #1;
        lv = 1'b1; ld = d;
        @(negedge clk); #1;            // accepted on this edge
        push_frame(d, cpb, lsb);
        lv = 1'b0; ld = ~d;            // post-acceptance data change
        if (poke && flen > 20) begin
            repeat (8) @(negedge clk);
            #1; lv = 1'b1; ld = 8'h3C; // offered while busy: must be ignored
            repeat (4) @(negedge clk);
            #1; lv = 1'b0;
            repeat (flen - 12) @(negedge clk);
        end else begin
            repeat (flen) @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic b2b(input logic [7:0] d1, input logic [7:0] d2, input int cpb, input bit lsb);
        int flen;
        flen = (8 + 2 + PAR) * cpb;
        @(negedge clk); #1;
        lv = 1'b1; ld = d1;
        @(negedge clk); #1;
        push_frame(d1, cpb, lsb);
        ld = d2;
        repeat (flen) @(negedge clk); // handoff edge: d2 accepted here
        #1;
        push_frame(d2, cpb, lsb);
        lv = 1'b0;
        repeat (flen + 3) @(negedge clk);
    endtask

    task automatic reset_mid_frame(input logic [7:0] d);
        @(negedge clk); #1;
        lv = 1'b1; ld = d;
        @(negedge clk); #1;
        push_frame(d, 4, 1'b1);
        lv = 1'b0;
        repeat (17) @(negedge clk);   // now inside data bit 3
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid", {28'd0, sdo_a, busy_a, done_a, ready_a}, {28'd0, IDLE_EXP});
        sb_q.delete();
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sel    = 0;
        mon_en = 1'b0;
        lv     = 1'b0;
        ld     = 8'h00;
        rst    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", {28'd0, sdo_a, busy_a, done_a, ready_a}, {28'd0, IDLE_EXP});
        chk("reset_b", {28'd0, sdo_b, busy_b, done_b, ready_b}, {28'd0, IDLE_EXP});
        chk("reset_c", {28'd0, sdo_c, busy_c, done_c, ready_c}, {28'd0, IDLE_EXP});
        @(posedge clk); #2;
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (20) @(negedge clk);

        sel = 0;
        send(8'hA5, 4, 1'b1, 1'b1);
        send(8'h07, 4, 1'b1, 1'b0);
        send(8'h03, 4, 1'b1, 1'b0);
        b2b(8'h00, 8'hFF, 4, 1'b1);
        reset_mid_frame(8'hA5);
        send(8'hA5, 4, 1'b1, 1'b0);

        sel = 1;
        send(8'h81, 4, 1'b0, 1'b0);
        send(8'h07, 4, 1'b0, 1'b1);
        b2b(8'h00, 8'hFF, 4, 1'b0);

        sel = 2;
        send(8'hA5, 1, 1'b1, 1'b0);
        b2b(8'h81, 8'h7E, 1, 1'b1);
        send(8'h03, 1, 1'b1, 1'b0);

        repeat (5) @(negedge clk);
        mon_en = 1'b0;
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
